// File: rtl/i2c_multi_target.sv
// i2c_multi_target: I2C target answering NUM_TARGETS consecutive addresses, each with a byte bank and auto-increment pointer.
// Define I2C_GENERAL_CALL_EN to ACK general-call writes (address 0, W) and broadcast them to every bank.
module i2c_multi_target #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TARGETS = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 7'h22,
    parameter int REG_DEPTH = 16,
    parameter int SYNC_STAGES = 2,
    localparam int PTR_W = $clog2(REG_DEPTH),
    localparam int TGT_W = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic                  ld_valid,
    input  logic [TGT_W-1:0]      ld_target,
    input  logic [PTR_W-1:0]      ld_reg,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy,
    output logic                  wr_strobe,
    output logic [TGT_W-1:0]      wr_target,
    output logic [PTR_W-1:0]      wr_reg,
    output logic [DATA_WIDTH-1:0] wr_data
);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int SH_W = DATA_WIDTH > AW1 ? DATA_WIDTH : AW1;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(AW1);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  scl_sync_q, sda_sync_q;
    logic                    scl_prev_q, sda_prev_q;
    logic                    scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [SH_W-1:0]         shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [TGT_W-1:0]        tgt_q, tgt_d;
    logic                    rw_q, rw_d, gc_q, gc_d, ack_q, ack_d, oe_q, oe_d, busy_q;
    logic                    wr_q, wr_d;
    logic [TGT_W-1:0]        wr_target_q, wr_target_d;
    logic [PTR_W-1:0]        wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    ptr_load, ptr_inc;
    logic [PTR_W-1:0]        ptr_q [NUM_TARGETS];
    logic [DATA_WIDTH-1:0]   mem_q [NUM_TARGETS][REG_DEPTH];
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    addr_hit, gc_hit, hit, addr_done, byte_done;
    logic [DATA_WIDTH-1:0]   cur_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s && !scl_prev_q;
    assign scl_fall  = !scl_s && scl_prev_q;
    assign start_det = scl_s && scl_prev_q && sda_prev_q && !sda_s;
    assign stop_det  = scl_s && scl_prev_q && !sda_prev_q && sda_s;

    assign addr      = shift_q[ADDR_WIDTH:1];
    assign addr_hit  = addr >= BASE_ADDR && {1'b0, addr} < {1'b0, BASE_ADDR} + AW1'(NUM_TARGETS);
`ifdef I2C_GENERAL_CALL_EN
    assign gc_hit    = addr == '0 && !shift_q[0];
`else
    assign gc_hit    = 1'b0;
`endif
    assign hit       = addr_hit || gc_hit;
    assign addr_done = cnt_q == ADDR_BITS;
    assign byte_done = cnt_q == BYTE_BITS;
    assign cur_byte  = mem_q[tgt_q][ptr_q[tgt_q]];

    assign sda_oe    = oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_q;
    assign wr_target = wr_target_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_det) state_d = ADDR;
        else if (stop_det) state_d = IDLE;
        else if (scl_fall) begin
            case (state_q)
                ADDR:      if (addr_done) state_d = hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  state_d = rw_q ? RDATA : PTR;
                PTR:       if (byte_done) state_d = PTR_ACK;
                PTR_ACK:   state_d = WDATA;
                WDATA:     if (byte_done) state_d = WDATA_ACK;
                WDATA_ACK: state_d = WDATA;
                RDATA:     if (byte_done) state_d = RACK;
                RACK:      state_d = ack_q ? RDATA : WAIT_STOP;
                default:   state_d = state_q;
            endcase
        end
    end

    // Bits are captured on SCL rise; SDA drive decisions are made on SCL fall.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        tgt_d       = tgt_q;
        rw_d        = rw_q;
        gc_d        = gc_q;
        ack_d       = ack_q;
        oe_d        = oe_q;
        wr_d        = 1'b0;
        wr_target_d = wr_target_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;
        if (start_det) begin
            cnt_d = '0;
            oe_d  = 1'b0;
            gc_d  = 1'b0;
        end else if (stop_det) begin
            oe_d = 1'b0;
        end else if (scl_rise) begin
            if (state_q inside {ADDR, PTR, WDATA}) begin
                shift_d = {shift_q[SH_W-2:0], sda_s};
                cnt_d   = cnt_q + 1'b1;
            end
            if (state_q == RDATA) cnt_d = cnt_q + 1'b1;
            if (state_q == RACK) ack_d = !sda_s;
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (addr_done) begin
                    oe_d  = hit;
                    cnt_d = '0;
                    rw_d  = shift_q[0];
                    gc_d  = gc_hit;
                    tgt_d = gc_hit ? '0 : TGT_W'(addr - BASE_ADDR);
                end
                ADDR_ACK: begin
                    cnt_d = '0;
                    tx_d  = cur_byte;
                    oe_d  = rw_q && !cur_byte[DATA_WIDTH-1];
                end
                PTR: if (byte_done) begin
                    oe_d     = 1'b1;
                    cnt_d    = '0;
                    ptr_load = 1'b1;
                end
                PTR_ACK, WDATA_ACK: oe_d = 1'b0;
                WDATA: if (byte_done) begin
                    oe_d        = 1'b1;
                    cnt_d       = '0;
                    wr_d        = 1'b1;
                    wr_target_d = tgt_q;
                    wr_reg_d    = ptr_q[tgt_q];
                    wr_data_d   = shift_q[DATA_WIDTH-1:0];
                end
                RDATA: begin
                    tx_d    = tx_q << 1;
                    oe_d    = byte_done ? 1'b0 : !tx_q[DATA_WIDTH-2];
                    cnt_d   = byte_done ? '0 : cnt_q;
                    ptr_inc = byte_done;
                end
                RACK: begin
                    cnt_d = '0;
                    tx_d  = cur_byte;
                    oe_d  = ack_q && !cur_byte[DATA_WIDTH-1];
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            tgt_q       <= '0;
            rw_q        <= 1'b0;
            gc_q        <= 1'b0;
            ack_q       <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            wr_target_q <= '0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            tgt_q       <= tgt_d;
            rw_q        <= rw_d;
            gc_q        <= gc_d;
            ack_q       <= ack_d;
            oe_q        <= oe_d;
            busy_q      <= start_det ? 1'b1 : stop_det ? 1'b0 : busy_q;
            wr_q        <= wr_d;
            wr_target_q <= wr_target_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // I2C writes come after the preload so they win on a same-byte collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                ptr_q[t] <= '0;
                for (int r = 0; r < REG_DEPTH; r++) mem_q[t][r] <= '0;
            end
        end else begin
            if (ld_valid && int'(ld_target) < NUM_TARGETS) mem_q[ld_target][ld_reg] <= ld_data;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (wr_q && (gc_q || wr_target_q == TGT_W'(t))) mem_q[t][wr_reg_q] <= wr_data_q;
                if (ptr_load && (gc_q || tgt_q == TGT_W'(t)))
                    ptr_q[t] <= shift_q[PTR_W-1:0];
                else if ((ptr_inc && tgt_q == TGT_W'(t)) || (wr_q && (gc_q || wr_target_q == TGT_W'(t))))
                    ptr_q[t] <= ptr_q[t] + 1'b1;
            end
        end
    end
endmodule

// File: doc/i2c_multi_target.md
# i2c_multi_target

Synthesizable, parametrised I2C target serving NUM_TARGETS consecutive 7-bit addresses. Each target owns a byte register bank with an auto-incrementing pointer. It supports START, repeated START, STOP, ACK/NACK and multi-byte burst read and write. It sits behind the open-drain SCL/SDA pads of the i2cmb DUT environment, oversampling the bus on the system clock, and replaces the behavioural target for gate-level and FPGA runs.

## Interface
- ADDR_WIDTH, 7: I2C address width.
- DATA_WIDTH, 8: data byte width; also the pointer byte width.
- NUM_TARGETS, 2: number of targets; target i answers BASE_ADDR+i.
- BASE_ADDR, 7'h22: address of target 0.
- REG_DEPTH, 16: bytes per bank, power of two; PTR_W = $clog2(REG_DEPTH).
- SYNC_STAGES, 2: synchroniser depth on scl_i/sda_i, minimum 2.

Ports:
- clk  in  1  system clock; must be at least 16x SCL frequency.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- ld_valid  in  1  host preload strobe.
- ld_target  in  $clog2(NUM_TARGETS)  preload target index.
- ld_reg  in  PTR_W  preload register index.
- ld_data  in  DATA_WIDTH  preload data.
- busy  out  1  high from START detect until STOP detect.
- wr_strobe  out  1  one-cycle pulse per byte written over I2C.
- wr_target, wr_reg, wr_data  out  widths as ld_*  write event; valid with wr_strobe.

## Operation
- scl_i and sda_i pass through SYNC_STAGES flops; edges are detected on the synchronised copies.
- START or repeated START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Bits are sampled on SCL rising edges. sda_oe changes only on SCL falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- START from any state goes to ADDR with the bit counter cleared. STOP from any state goes to IDLE and releases SDA.
- ADDR collects ADDR_WIDTH address bits plus the R/W bit, MSB first.
  - Address in [BASE_ADDR, BASE_ADDR+NUM_TARGETS-1]: select that target and ACK.
  - Otherwise: NACK (SDA not driven) and go to WAIT_STOP, which ignores all bits until START or STOP.
- Write (R/W=0):
  - First byte sets the pointer: ptr = byte[PTR_W-1:0]; upper bits ignored. ACK.
  - Each later byte: reg[ptr] <= byte, ACK, then ptr <= ptr+1 mod REG_DEPTH (wraps from REG_DEPTH-1 to 0).
- Read (R/W=1):
  - Drive reg[ptr] MSB first, releasing SDA for each 1 bit.
  - On RACK, sample the controller's ACK; ptr increments after every transmitted byte.
  - Controller ACK: send the next byte. Controller NACK: release SDA and go to WAIT_STOP.
- Each target keeps its pointer across transactions, so write-pointer / repeated START / read reads from the set pointer.
- Preload: ld_valid writes ld_data into bank ld_target at ld_reg in one clk.
  - If an I2C write hits the same byte in the same cycle, the I2C write wins.
  - ld_target >= NUM_TARGETS is ignored.

## Timing
- Reset: sda_oe=0, busy=0, wr_strobe=0, wr_target/wr_reg/wr_data=0, all registers 0, all pointers 0, FSM in IDLE.
- Reset mid-transfer releases SDA immediately (asynchronous). The FSM resumes only on the next START.
- Pad-to-internal latency: SYNC_STAGES clk. sda_oe updates SYNC_STAGES+1 clk after the SCL falling edge at the pin.
- busy rises 1 clk after START is detected and falls 1 clk after STOP is detected.
- wr_strobe pulses in the same clk that sda_oe asserts the data ACK. The register update is visible on the following clk.
- Repeated START with no STOP: busy stays high.

## Configuration
- I2C_GENERAL_CALL_EN defined:
  - Address 7'h00 with W is ACKed.
  - The following pointer and data bytes are written to the same register in every bank.
  - wr_strobe pulses once per byte with wr_target=0.
  - 7'h00 with R is NACKed.
- I2C_GENERAL_CALL_EN undefined: 7'h00 is treated as any other non-matching address (NACK, WAIT_STOP).

## Test plan
- Write 0x22/W, ptr 0x03, data 0xA5, 0x5A, STOP -> all three bytes ACKed; target 0 reg3=0xA5, reg4=0x5A; two wr_strobe pulses.
- 0x23/W ptr 0x0F, data 0x11, 0x22; then repeated START 0x23/R, read 1 byte -> writes land in reg15=0x11 and reg0=0x22 (wrap); read returns reg1=0x00 and the controller NACKs.
- Preload target 0 reg0..2 = 0x10,0x20,0x30; 0x22/W ptr 0x00; repeated START 0x22/R; read 3 bytes with ACK,ACK,NACK -> returns 0x10,0x20,0x30; SDA released after the NACK.
- Address 0x40/W followed by 2 bytes -> no ACK anywhere, sda_oe stays 0, no wr_strobe, registers unchanged.
- rst_n pulsed low during the 4th data bit of a read -> sda_oe=0 within the reset cycle; the next 0x22/R returns 0x00.
- With I2C_GENERAL_CALL_EN: 0x00/W ptr 0x02, data 0x77 -> reg2=0x77 in both banks. Without it: NACK and no change.
